// File: rtl/iso_rx_lane_parser.sv
// rtl/iso_rx_lane_parser.sv - single-lane main-link parser recovering VB-ID, MSA and RGB pixels.
// All outputs are flops loaded one cycle after the triggering symbol.
module iso_rx_lane_parser #(
   parameter logic [7:0] BS_SYM    = 8'hBC,
   parameter logic [7:0] BE_SYM    = 8'hFB,
   parameter logic [7:0] SS_SYM    = 8'h5C,
   parameter logic [7:0] SE_SYM    = 8'hFD,
   parameter logic [7:0] FS_SYM    = 8'hFE,
   parameter logic [7:0] FE_SYM    = 8'hF7,
   parameter int         MSA_BYTES = 24
) (
   input  logic                     ls_clk,
   input  logic                     rst,
   input  logic [7:0]               iso_symbols_lane0,
   input  logic                     iso_control_sym_flag_lane0,
   output logic [7:0]               rx_vbid,
   output logic                     rx_vblank,
   output logic [8*MSA_BYTES-1:0]   rx_msa,
   output logic                     rx_msa_vld,
   output logic [23:0]              rx_pixel,
   output logic                     rx_pixel_vld,
   output logic                     rx_line_start,
   output logic                     rx_err
);

   typedef enum logic [2:0] {SEEK, BS_HDR, BLANK, SDP, ACTIVE, FILL} state_t;

   state_t                  state_q, state_d;
   logic [1:0]              hdr_cnt_q, hdr_cnt_d;
   logic [4:0]              cnt_q, cnt_d;
   logic                    ss2_q, ss2_d;
   logic [1:0]              phase_q, phase_d;
   logic [7:0]              b0_q, b0_d, b1_q, b1_d;
   logic [8*MSA_BYTES-1:0]  stage_q, stage_d;
   logic [8*MSA_BYTES-1:0]  msa_q, msa_d;
   logic [7:0]              vbid_q, vbid_d;
   logic [23:0]             pixel_q, pixel_d;
   logic                    msa_vld_q, msa_vld_d;
   logic                    pixel_vld_q, pixel_vld_d;
   logic                    line_q, line_d;
   logic                    err_q, err_d;

   logic       is_ctrl;
   logic [7:0] sym;
   logic       msa_full;

   assign is_ctrl  = iso_control_sym_flag_lane0;
   assign sym      = iso_symbols_lane0;
   assign msa_full = (cnt_q == 5'(MSA_BYTES));

   always_comb begin
      state_d     = state_q;
      hdr_cnt_d   = hdr_cnt_q;
      cnt_d       = cnt_q;
      ss2_d       = ss2_q;
      phase_d     = phase_q;
      b0_d        = b0_q;
      b1_d        = b1_q;
      stage_d     = stage_q;
      msa_d       = msa_q;
      vbid_d      = vbid_q;
      pixel_d     = pixel_q;
      msa_vld_d   = 1'b0;
      pixel_vld_d = 1'b0;
      line_d      = 1'b0;
      err_d       = 1'b0;

      // BS re-synchronises every state; only ACTIVE with a partial pixel and FILL flag it.
      if (is_ctrl && sym == BS_SYM) begin
         state_d   = BS_HDR;
         hdr_cnt_d = 2'd0;
         err_d     = (state_q == FILL) || (state_q == ACTIVE && phase_q != 2'd0);
      end else begin
         case (state_q)
            SEEK: ;
            BS_HDR: begin
               if (is_ctrl) begin
                  err_d   = 1'b1;
                  state_d = SEEK;
               end else begin
                  if (hdr_cnt_q == 2'd0) vbid_d = sym;
                  if (hdr_cnt_q == 2'd2) begin
                     state_d   = BLANK;
                     hdr_cnt_d = 2'd0;
                  end else begin
                     hdr_cnt_d = hdr_cnt_q + 2'd1;
                  end
               end
            end
            BLANK: begin
               if (is_ctrl) begin
                  if (sym == SS_SYM) begin
                     state_d = SDP;
                     cnt_d   = 5'd0;
                     ss2_d   = 1'b0;
                  end else if (sym == BE_SYM) begin
                     state_d = ACTIVE;
                     line_d  = 1'b1;
                     phase_d = 2'd0;
                  end else begin
                     err_d   = 1'b1;
                     state_d = SEEK;
                  end
               end
            end
            SDP: begin
               if (!is_ctrl) begin
                  if (msa_full) begin
                     err_d   = 1'b1;
                     state_d = BLANK;
                  end else begin
                     stage_d[{cnt_q, 3'b000} +: 8] = sym;
                     cnt_d = cnt_q + 5'd1;
                  end
               end else if (sym == SS_SYM && cnt_q == 5'd0 && !ss2_q) begin
                  ss2_d = 1'b1;
               end else if (sym == SE_SYM) begin
                  state_d = BLANK;
                  if (msa_full) begin
                     msa_d     = stage_q;
                     msa_vld_d = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end else begin
                  err_d   = 1'b1;
                  state_d = SEEK;
               end
            end
            ACTIVE: begin
               if (!is_ctrl) begin
                  case (phase_q)
                     2'd0: begin b0_d = sym; phase_d = 2'd1; end
                     2'd1: begin b1_d = sym; phase_d = 2'd2; end
                     default: begin
                        pixel_d     = {b0_q, b1_q, sym};
                        pixel_vld_d = 1'b1;
                        phase_d     = 2'd0;
                     end
                  endcase
               end else if (sym == FS_SYM) begin
                  state_d = FILL;
               end else begin
                  err_d   = 1'b1;
                  state_d = SEEK;
               end
            end
            FILL: begin
               if (is_ctrl) begin
                  if (sym == FE_SYM) begin
                     state_d = ACTIVE;
                  end else begin
                     err_d   = 1'b1;
                     state_d = SEEK;
                  end
               end
            end
            default: state_d = SEEK;
         endcase
      end
   end

   always_ff @(posedge ls_clk) begin
      if (rst) begin
         state_q     <= SEEK;
         hdr_cnt_q   <= '0;
         cnt_q       <= '0;
         ss2_q       <= 1'b0;
         phase_q     <= '0;
         b0_q        <= '0;
         b1_q        <= '0;
         stage_q     <= '0;
         msa_q       <= '0;
         vbid_q      <= '0;
         pixel_q     <= '0;
         msa_vld_q   <= 1'b0;
         pixel_vld_q <= 1'b0;
         line_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         hdr_cnt_q   <= hdr_cnt_d;
         cnt_q       <= cnt_d;
         ss2_q       <= ss2_d;
         phase_q     <= phase_d;
         b0_q        <= b0_d;
         b1_q        <= b1_d;
         stage_q     <= stage_d;
         msa_q       <= msa_d;
         vbid_q      <= vbid_d;
         pixel_q     <= pixel_d;
         msa_vld_q   <= msa_vld_d;
         pixel_vld_q <= pixel_vld_d;
         line_q      <= line_d;
         err_q       <= err_d;
      end
   end

   assign rx_vbid       = vbid_q;
   assign rx_vblank     = vbid_q[0];
   assign rx_msa        = msa_q;
   assign rx_msa_vld    = msa_vld_q;
   assign rx_pixel      = pixel_q;
   assign rx_pixel_vld  = pixel_vld_q;
   assign rx_line_start = line_q;
   assign rx_err        = err_q;

endmodule

// File: tb/tb_iso_rx_lane_parser.sv
// tb/tb_iso_rx_lane_parser.sv - scoreboard bench for iso_rx_lane_parser.
// Stimulus pushes expected output events; a negedge monitor pops and compares them.
module tb_iso_rx_lane_parser;

   localparam int K_VBID = 0;
   localparam int K_MSA  = 1;
   localparam int K_PIX  = 2;
   localparam int K_LINE = 3;
   localparam int K_ERR  = 4;

   typedef struct {
      int           kind;
      logic [191:0] data;
   } ev_t;

   logic         ls_clk = 1'b0;
   logic         rst = 1'b1;
   logic [7:0]   iso_symbols_lane0 = 8'h00;
   logic         iso_control_sym_flag_lane0 = 1'b0;
   logic [7:0]   rx_vbid;
   logic         rx_vblank;
   logic [191:0] rx_msa;
   logic         rx_msa_vld;
   logic [23:0]  rx_pixel;
   logic         rx_pixel_vld;
   logic         rx_line_start;
   logic         rx_err;

   ev_t          exp_q[$];
   int           tests = 0;
   int           fails = 0;
   logic         rst_at_edge = 1'b1;
   logic [7:0]   prev_vbid = 8'h00;
   logic [191:0] msa_a, msa_b;

   iso_rx_lane_parser dut (
      .ls_clk                     (ls_clk),
      .rst                        (rst),
      .iso_symbols_lane0          (iso_symbols_lane0),
      .iso_control_sym_flag_lane0 (iso_control_sym_flag_lane0),
      .rx_vbid                    (rx_vbid),
      .rx_vblank                  (rx_vblank),
      .rx_msa                     (rx_msa),
      .rx_msa_vld                 (rx_msa_vld),
      .rx_pixel                   (rx_pixel),
      .rx_pixel_vld               (rx_pixel_vld),
      .rx_line_start              (rx_line_start),
      .rx_err                     (rx_err)
   );

   always #5 ls_clk = ~ls_clk;

   always @(posedge ls_clk) rst_at_edge <= rst;

   function automatic string kname(input int k);
      case (k)
         K_VBID:  return "vbid";
         K_MSA:   return "msa";
         K_PIX:   return "pixel";
         K_LINE:  return "line_start";
         default: return "err";
      endcase
   endfunction

   task automatic push(input int kind, input logic [191:0] data);
      ev_t e;
      e.kind = kind;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int kind, input logic [191:0] data);
      ev_t e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL unexpected_%s: got %h, expected no event", kname(kind), data);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.data != data) begin
            fails++;
            $display("FAIL event_%s: got %s %h, expected %s %h",
                     kname(e.kind), kname(kind), data, kname(e.kind), e.data);
         end
      end
   endtask

   // Monitor: pulses and VB-ID changes become observed events, in a fixed order per cycle.
   initial begin
      forever begin
         @(negedge ls_clk);
         if (rst_at_edge) begin
            tests++;
            if (rx_vbid != 8'h00 || rx_vblank || rx_msa != '0 || rx_msa_vld || rx_pixel != '0 ||
                rx_pixel_vld || rx_line_start || rx_err) begin
               fails++;
               $display("FAIL reset_outputs: got vbid=%h msa_vld=%b pix=%h pix_vld=%b line=%b err=%b, expected all zero",
                        rx_vbid, rx_msa_vld, rx_pixel, rx_pixel_vld, rx_line_start, rx_err);
            end
            prev_vbid = rx_vbid;
         end else begin
            if (rx_vbid != prev_vbid) begin
               observe(K_VBID, {183'd0, rx_vblank, rx_vbid});
               prev_vbid = rx_vbid;
            end
            if (rx_msa_vld)    observe(K_MSA, rx_msa);
            if (rx_pixel_vld)  observe(K_PIX, {168'd0, rx_pixel});
            if (rx_line_start) observe(K_LINE, '0);
            if (rx_err)        observe(K_ERR, '0);
         end
      end
   end

   task automatic send(input logic ctrl, input logic [7:0] s);
      iso_control_sym_flag_lane0 = ctrl;
      iso_symbols_lane0 = s;
      @(posedge ls_clk);
      #1;
   endtask

   task automatic d(input logic [7:0] s);
      send(1'b0, s);
   endtask

   task automatic c(input logic [7:0] s);
      send(1'b1, s);
   endtask

   task automatic hdr(input logic [7:0] v);
      c(8'hBC);
      push(K_VBID, {183'd0, v[0], v});
      d(v);
      d(8'h00);
      d(8'h00);
   endtask

   task automatic do_reset();
      iso_control_sym_flag_lane0 = 1'b0;
      iso_symbols_lane0 = 8'h00;
      rst = 1'b1;
      repeat (3) @(posedge ls_clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic check_msa(input string name, input logic [191:0] want);
      tests++;
      if (rx_msa != want) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, rx_msa, want);
      end
   endtask

   initial begin
      for (int k = 0; k < 24; k++) begin
         msa_a[8*k +: 8] = 8'(k);
         msa_b[8*k +: 8] = 8'(8'hA0 + k);
      end

      do_reset();

      // SEEK ignores data and every control code except BS.
      d(8'h00); d(8'hBC); d(8'h5C); d(8'hFD); d(8'h12); d(8'h34);
      c(8'hFE); c(8'hFB); c(8'hFD); c(8'hF7);

      hdr(8'h01);
      repeat (4) d(8'hAA);

      hdr(8'h05);
      c(8'h5C); c(8'h5C);
      for (int k = 0; k < 24; k++) d(8'(k));
      push(K_MSA, msa_a);
      c(8'hFD);

      c(8'h5C); c(8'h5C);
      for (int k = 0; k < 23; k++) d(8'(k + 8'h30));
      push(K_ERR, '0);
      c(8'hFD);
      check_msa("msa_after_short", msa_a);

      // 25th byte overflows the MSA; SE in BLANK is then unexpected.
      c(8'h5C);
      for (int k = 0; k < 24; k++) d(8'(k + 8'hC0));
      push(K_ERR, '0);
      d(8'hEE);
      push(K_ERR, '0);
      c(8'hFD);
      check_msa("msa_after_overflow", msa_a);

      hdr(8'h07);
      push(K_LINE, '0);
      c(8'hFB);
      push(K_PIX, {168'd0, 24'hBBBBBB});
      d(8'hBB); d(8'hBB); d(8'hBB);
      push(K_PIX, {168'd0, 24'h112233});
      d(8'h11); d(8'h22); d(8'h33);
      c(8'hFE); d(8'hAA); d(8'hAA); c(8'hF7);
      push(K_PIX, {168'd0, 24'h445566});
      d(8'h44); d(8'h55); d(8'h66);

      hdr(8'h08);
      push(K_LINE, '0);
      c(8'hFB);
      d(8'h11); d(8'h22);
      push(K_ERR, '0);
      c(8'hBC);
      push(K_VBID, {183'd0, 1'b0, 8'h40});
      d(8'h40); d(8'h41); d(8'h42);
      push(K_ERR, '0);
      c(8'hF7);

      hdr(8'h09);
      c(8'h5C); c(8'h5C);
      for (int k = 0; k < 10; k++) d(8'(k + 8'h60));
      do_reset();
      hdr(8'h0A);
      c(8'h5C); c(8'h5C);
      for (int k = 0; k < 24; k++) d(8'(8'hA0 + k));
      push(K_MSA, msa_b);
      c(8'hFD);
      check_msa("msa_after_reset", msa_b);

      repeat (4) d(8'h00);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL pending_events: got %0d left, expected 0 (next %s)",
                  exp_q.size(), kname(exp_q[0].kind));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
